// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants: ROB geometry, rename tags and opcode encodings.
package tomasulo_pkg;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned FUNC_W    = 4;
  localparam int unsigned TAG_W     = IDX_W + 1;

  // Rename tag meaning "the value lives in the register bank".
  localparam logic [TAG_W-1:0] TAG_NONE = 4'd8;

  // Opcodes shared by issue, reservation stations and the ROB.
  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD  = 4'd0,
    FUNC_SUB  = 4'd1,
    FUNC_AND  = 4'd2,
    FUNC_OR   = 4'd3,
    FUNC_XOR  = 4'd4,
    FUNC_SLL  = 4'd5,
    FUNC_SRL  = 4'd6,
    FUNC_MUL  = 4'd7,
    FUNC_LOAD = 4'd8,
    FUNC_NOP  = 4'd15
  } func_e;

  // Retire payload as seen by the register-bank owner.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] data;
  } rob_ret_t;

endpackage

// File: rtl/rob_retire.sv
// Reorder buffer: tail allocation from issue, CDB completion, in-order retire from head.
module rob_retire #(
  parameter int unsigned DEPTH  = tomasulo_pkg::ROB_DEPTH,
  parameter int unsigned IDX_W  = tomasulo_pkg::IDX_W,
  parameter int unsigned DATA_W = tomasulo_pkg::DATA_W,
  parameter int unsigned REG_W  = tomasulo_pkg::REG_W,
  parameter int unsigned FUNC_W = tomasulo_pkg::FUNC_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cdb_valid,
  input  logic [IDX_W-1:0]  cdb_idx,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              ret_valid,
  output logic [IDX_W-1:0]  ret_idx,
  output logic [REG_W-1:0]  ret_rd,
  output logic [FUNC_W-1:0] ret_func,
  output logic [DATA_W-1:0] ret_data,
  output logic              cdb_err,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_W = IDX_W + 1;

  // Per-field entry storage.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q,  done_d;
  logic [FUNC_W-1:0] func_q [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [IDX_W-1:0]  head_q,  head_d;
  logic [IDX_W-1:0]  tail_q,  tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q,  empty_q;

  logic              ret_valid_q;
  logic [IDX_W-1:0]  ret_idx_q;
  logic [REG_W-1:0]  ret_rd_q;
  logic [FUNC_W-1:0] ret_func_q;
  logic [DATA_W-1:0] ret_data_q;
  logic              cdb_err_q;

  logic              accept_c;
  logic              retire_c;
  logic              cdb_ok_c;
  logic              cdb_bad_c;

  // Handshake decode. A CDB aimed at the tail being allocated sees valid=0 there
  // (tail is never valid unless full), so allocate wins and the CDB reports an error.
  always_comb begin
    accept_c  = alloc_valid && !full_q && !flush;
    retire_c  = !flush && valid_q[head_q] && done_q[head_q];
    cdb_ok_c  = !flush && cdb_valid && valid_q[cdb_idx] && !done_q[cdb_idx];
    cdb_bad_c = !flush && cdb_valid && !(valid_q[cdb_idx] && !done_q[cdb_idx]);
  end

  // Next-state for pointers, occupancy and per-entry valid/done bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (accept_c) tail_d = tail_q + IDX_W'(1);
      if (retire_c) head_d = head_q + IDX_W'(1);
      count_d = count_q + CNT_W'(accept_c) - CNT_W'(retire_c);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (accept_c && (tail_q == IDX_W'(i))) begin
          valid_d[i] = 1'b1;
          done_d[i]  = 1'b0;
        end else if (retire_c && (head_q == IDX_W'(i))) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end else if (cdb_ok_c && (cdb_idx == IDX_W'(i))) begin
          done_d[i]  = 1'b1;
        end
      end
    end
  end

  // Control state and registered retire/error outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ret_valid_q <= 1'b0;
      ret_idx_q   <= '0;
      ret_rd_q    <= '0;
      ret_func_q  <= '0;
      ret_data_q  <= '0;
      cdb_err_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      full_q      <= (count_d == CNT_W'(DEPTH));
      empty_q     <= (count_d == '0);
      ret_valid_q <= retire_c;
      cdb_err_q   <= cdb_bad_c;
      if (retire_c) begin
        ret_idx_q  <= head_q;
        ret_rd_q   <= rd_q[head_q];
        ret_func_q <= func_q[head_q];
        ret_data_q <= data_q[head_q];
      end
    end
  end

  // Entry payload; qualified by the valid/done bits so it needs no reset.
  always_ff @(posedge clk1) begin
    if (accept_c) begin
      func_q[tail_q] <= alloc_func;
      rd_q[tail_q]   <= alloc_rd;
    end
    if (cdb_ok_c) data_q[cdb_idx] <= cdb_data;
  end

  assign alloc_ready = !full_q;
  assign alloc_idx   = tail_q;
  assign ret_valid   = ret_valid_q;
  assign ret_idx     = ret_idx_q;
  assign ret_rd      = ret_rd_q;
  assign ret_func    = ret_func_q;
  assign ret_data    = ret_data_q;
  assign cdb_err     = cdb_err_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_rob_retire.sv
// Scoreboard bench for rob_retire: stimulus queues expected retires/errors, a monitor checks them.
module tb_rob_retire;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [3:0]  alloc_func;
  logic [3:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_idx;
  logic        cdb_valid;
  logic [2:0]  cdb_idx;
  logic [15:0] cdb_data;
  logic        flush;
  logic        ret_valid;
  logic [2:0]  ret_idx;
  logic [3:0]  ret_rd;
  logic [3:0]  ret_func;
  logic [15:0] ret_data;
  logic        cdb_err;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  rob_retire dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_func  (alloc_func),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .cdb_valid   (cdb_valid),
    .cdb_idx     (cdb_idx),
    .cdb_data    (cdb_data),
    .flush       (flush),
    .ret_valid   (ret_valid),
    .ret_idx     (ret_idx),
    .ret_rd      (ret_rd),
    .ret_func    (ret_func),
    .ret_data    (ret_data),
    .cdb_err     (cdb_err),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic [2:0]  idx;
    logic [3:0]  rd;
    logic [3:0]  func;
    logic [15:0] data;
  } exp_ret_t;

  exp_ret_t ret_q[$];
  int       err_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  exp_ret_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ret(input int c, input logic [2:0] idx, input logic [3:0] rd,
                          input logic [3:0] func, input logic [15:0] data);
    exp_ret_t x;
    x.cyc = c; x.idx = idx; x.rd = rd; x.func = func; x.data = data;
    ret_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_cdb(input logic v, input logic [2:0] idx, input logic [15:0] data);
    cdb_valid = v; cdb_idx = idx; cdb_data = data;
  endtask

  // Monitor: pops expectations whenever the DUT presents a retire or CDB error.
  always @(negedge clk1) begin
    while (ret_q.size() > 0 && ret_q[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL ret_missing: expected idx %0d at cycle %0d, ret_valid stayed low", ret_q[0].idx, ret_q[0].cyc);
      ret_q.delete(0);
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL err_missing: expected cdb_err at cycle %0d, cdb_err stayed low", err_q[0]);
      err_q.delete(0);
    end
    if (ret_valid) begin
      n_checks++;
      if (ret_q.size() == 0) begin
        n_fail++;
        $display("FAIL ret_unexpected: ret_valid idx %0d at cycle %0d, none expected", ret_idx, cyc);
      end else begin
        e = ret_q.pop_front();
        if (e.cyc != cyc || {ret_idx, ret_rd, ret_func, ret_data} !== {e.idx, e.rd, e.func, e.data}) begin
          n_fail++;
          $display("FAIL ret_payload: got cyc %0d idx %0d rd %0d func %0d data 0x%0h, expected cyc %0d idx %0d rd %0d func %0d data 0x%0h",
                   cyc, ret_idx, ret_rd, ret_func, ret_data, e.cyc, e.idx, e.rd, e.func, e.data);
        end
      end
    end
    if (cdb_err) begin
      n_checks++;
      if (err_q.size() == 0) begin
        n_fail++;
        $display("FAIL err_unexpected: cdb_err at cycle %0d, none expected", cyc);
      end else if (err_q[0] != cyc) begin
        n_fail++;
        $display("FAIL err_timing: cdb_err at cycle %0d, expected cycle %0d", cyc, err_q[0]);
        err_q.delete(0);
      end else begin
        err_q.delete(0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int t0;

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
    flush = 1'b0; set_cdb(1'b0, 3'd0, 16'h0);
    repeat (2) @(posedge clk1);
    #1;
    // Reset values
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    check("rst_ret_valid", 32'(ret_valid), 32'd0);
    check("rst_ret_payload", 32'({ret_idx, ret_rd, ret_func, ret_data}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single alloc -> CDB -> retire, 3 cycles alloc to ret_valid
    alloc_valid = 1'b1; alloc_func = 4'd1; alloc_rd = 4'd3;
    check("t1_alloc_idx", 32'(alloc_idx), 32'd0);
    tick();
    alloc_valid = 1'b0;
    check("t1_count", 32'(count), 32'd1);
    set_cdb(1'b1, 3'd0, 16'h00A5);
    push_ret(cyc + 2, 3'd0, 4'd3, 4'd1, 16'h00A5);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    repeat (2) tick();
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_count_after", 32'(count), 32'd0);

    // Three entries completed out of order, retired in order
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 1'b1; alloc_func = 4'(2 + k); alloc_rd = 4'(5 + k);
      check("t2_alloc_idx", 32'(alloc_idx), 32'(1 + k));
      tick();
    end
    alloc_valid = 1'b0;
    t0 = cyc;
    push_ret(t0 + 3, 3'd1, 4'd5, 4'd2, 16'h0111);
    push_ret(t0 + 4, 3'd2, 4'd6, 4'd3, 16'h0222);
    push_ret(t0 + 5, 3'd3, 4'd7, 4'd4, 16'h0333);
    set_cdb(1'b1, 3'd3, 16'h0333); tick();
    set_cdb(1'b1, 3'd1, 16'h0111); tick();
    set_cdb(1'b1, 3'd2, 16'h0222); tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    repeat (4) tick();
    check("t2_empty", 32'(empty), 32'd1);

    // CDB to empty slot, then repeated CDB to a done entry
    set_cdb(1'b1, 3'd6, 16'hFFFF);
    err_q.push_back(cyc + 1);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    alloc_valid = 1'b1; alloc_func = 4'd5; alloc_rd = 4'd1;
    check("t3_alloc_idx0", 32'(alloc_idx), 32'd4);
    tick();
    alloc_func = 4'd6; alloc_rd = 4'd2;
    check("t3_alloc_idx1", 32'(alloc_idx), 32'd5);
    tick();
    alloc_valid = 1'b0;
    set_cdb(1'b1, 3'd5, 16'h5555); tick();
    set_cdb(1'b1, 3'd5, 16'hDEAD);
    err_q.push_back(cyc + 1);
    tick();
    set_cdb(1'b1, 3'd4, 16'h4444);
    push_ret(cyc + 2, 3'd4, 4'd1, 4'd5, 16'h4444);
    push_ret(cyc + 3, 3'd5, 4'd2, 4'd6, 16'h5555);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    repeat (4) tick();
    check("t3_empty", 32'(empty), 32'd1);

    // Flush with 5 valid entries while alloc and CDB are active
    for (int k = 0; k < 5; k++) begin
      alloc_valid = 1'b1; alloc_func = 4'd7; alloc_rd = 4'(8 + k);
      tick();
    end
    alloc_valid = 1'b0;
    check("t4_count_pre", 32'(count), 32'd5);
    set_cdb(1'b1, 3'd6, 16'h6666);
    tick();
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_func = 4'd3; alloc_rd = 4'd3;
    set_cdb(1'b1, 3'd3, 16'h3333);
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    set_cdb(1'b0, 3'd0, 16'h0);
    check("t4_count", 32'(count), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_alloc_idx", 32'(alloc_idx), 32'd0);
    repeat (3) tick();

    // Fill to full, refused alloc in the retire cycle, wrap to idx 0
    for (int k = 0; k < 8; k++) begin
      alloc_valid = 1'b1; alloc_func = 4'(k); alloc_rd = 4'(15 - k);
      check("t5_alloc_idx", 32'(alloc_idx), 32'(k));
      tick();
    end
    alloc_valid = 1'b0;
    check("t5_full", 32'(full), 32'd1);
    check("t5_alloc_ready", 32'(alloc_ready), 32'd0);
    check("t5_count", 32'(count), 32'd8);
    check("t5_not_empty", 32'(empty), 32'd0);
    set_cdb(1'b1, 3'd0, 16'h00F0);
    push_ret(cyc + 2, 3'd0, 4'd15, 4'd0, 16'h00F0);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    alloc_valid = 1'b1; alloc_func = 4'd9; alloc_rd = 4'd9;
    tick();
    check("t5_count_refused", 32'(count), 32'd7);
    check("t5_ready_again", 32'(alloc_ready), 32'd1);
    check("t5_wrap_idx", 32'(alloc_idx), 32'd0);
    tick();
    alloc_valid = 1'b0;
    check("t5_count_refill", 32'(count), 32'd8);
    check("t5_full_again", 32'(full), 32'd1);
    check("t5_tail_after", 32'(alloc_idx), 32'd1);

    // Asynchronous reset mid-operation with entries pending
    set_cdb(1'b1, 3'd1, 16'h1111);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_full", 32'(full), 32'd0);
    check("t6_alloc_ready", 32'(alloc_ready), 32'd1);
    check("t6_alloc_idx", 32'(alloc_idx), 32'd0);
    check("t6_ret_valid", 32'(ret_valid), 32'd0);
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    alloc_valid = 1'b1; alloc_func = 4'd12; alloc_rd = 4'd10;
    check("t6_first_idx", 32'(alloc_idx), 32'd0);
    tick();
    alloc_valid = 1'b0;
    set_cdb(1'b1, 3'd0, 16'hBBBB);
    push_ret(cyc + 2, 3'd0, 4'd10, 4'd12, 16'hBBBB);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0);
    repeat (4) tick();
    check("t6_empty_end", 32'(empty), 32'd1);

    check("sb_ret_drained", 32'(ret_q.size()), 32'd0);
    check("sb_err_drained", 32'(err_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
